key_debounce_toggle: RTL and testbench

- Front end for the board push-buttons, sitting between the raw active-low KEY pins and the LED pins.
- Per key: synchronises the pin, debounces it, and emits a clean level plus a one-cycle press pulse.
- Each press pulse toggles a latched active-low LED output.
- Combinational key/LED logic elsewhere consumes key_level instead of raw pins.

---
 rtl/key_debounce_toggle.sv | 120 ++++++++++++
 tb/tb_key_debounce_toggle.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_toggle.sv
// Purpose : per-key synchroniser + debouncer + press strobe + toggle-latched active-low LED.
// Latency : clean pin edge reaches key_level DB_CYCLES+2 clocks after first sampling edge; press_pulse/led_n on that same edge.
// Backpressure: none; free-running, every output registered each clock.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (release synchronous to clk)
//   key_n       raw active-low key pins, asynchronous to clk
//   key_level   debounced key level (0 = pressed)
//   press_pulse one-cycle strobe per accepted press (and per auto-repeat)
//   led_n       toggle-latched LED drive (0 = lit)
//
// Optional build macro: KEY_AUTOREPEAT_EN -- adds a per-key repeat counter that
// re-strobes press_pulse (and toggles led_n) every REPEAT_CYCLES while held.
module key_debounce_toggle #(
  parameter int N_KEYS        = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] led_n
);

  localparam int             DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  // Two-flop synchroniser; both stages reset to the released level.
  logic [N_KEYS-1:0] sync1_q, sync2_q;

  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] pulse_q, pulse_d;
  logic [N_KEYS-1:0] led_q,   led_d;
  logic [N_KEYS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam int             RP_W   = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);

  logic [N_KEYS-1:0][RP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  always_comb begin
    level_d  = level_q;
    pulse_d  = '0;
    led_d    = led_q;
    db_cnt_d = db_cnt_q;
`ifdef KEY_AUTOREPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      // The counter only advances while the synchronised pin disagrees with
      // the accepted level, so any bounce back restarts it from zero.
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        db_cnt_d[i] = '0;
        level_d[i]  = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end

      // Press = accepted 1->0 transition; release produces nothing.
      pulse_d[i] = level_q[i] & ~level_d[i];

`ifdef KEY_AUTOREPEAT_EN
      // Count only while the key stays held across this edge; the press edge,
      // idle and release edge all park the counter at zero.
      if (level_q[i] | level_d[i]) begin
        rep_cnt_d[i] = '0;
      end else if (rep_cnt_q[i] == RP_MAX) begin
        rep_cnt_d[i] = '0;
        pulse_d[i]   = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + RP_W'(1);
      end
`endif

      if (pulse_d[i]) begin
        led_d[i] = ~led_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      level_q  <= '1;
      pulse_q  <= '0;
      led_q    <= '1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      led_q    <= led_d;
      db_cnt_q <= db_cnt_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign key_level   = level_q;
  assign press_pulse = pulse_q;
  assign led_n       = led_q;

endmodule

// File: tb/tb_key_debounce_toggle.sv
// Purpose : randomized + directed bench for key_debounce_toggle with a window-based reference model and scoreboard.
// Latency : expected outputs for each clock edge are queued before that edge and checked 1 time unit after it.
// Backpressure: none; one scoreboard entry per active clock edge.
module tb_key_debounce_toggle;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_n = '0;
  logic [N-1:0] key_level, press_pulse, led_n;

  always #5 clk = ~clk;

  key_debounce_toggle #(
    .N_KEYS       (N),
    .DB_CYCLES    (DB),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .press_pulse(press_pulse),
    .led_n      (led_n)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic [N-1:0] led;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: accepted level, LED latch, the last two pin values
  // (the pin reaches the debouncer two edges late), and a window of the last
  // DB synchronised samples per key.
  logic [N-1:0]    m_lvl, m_led, h1, h2;
  logic [DB-1:0]   wbuf [N];
  int              wcnt [N];
  int              press_edge [N];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '1;
    m_led = '1;
    h1    = '1;
    h2    = '1;
    cyc   = 0;
    for (int i = 0; i < N; i++) begin
      wbuf[i]       = '0;
      wcnt[i]       = 0;
      press_edge[i] = 0;
    end
  endtask

  // Drive one pin value before the next active edge and queue what the
  // outputs must be right after that edge.
  task automatic step(input logic [N-1:0] kn);
    logic [N-1:0] s, pls;
    logic         nl;
    exp_t         e;
    @(negedge clk);
    key_n = kn;
    cyc++;
    s  = h2;
    h2 = h1;
    h1 = kn;
    pls = '0;
    for (int i = 0; i < N; i++) begin
      wbuf[i] = {wbuf[i][DB-2:0], s[i]};
      if (wcnt[i] < DB) wcnt[i]++;
      nl = m_lvl[i];
      // Accept once the last DB samples all show the opposite level.
      if (wcnt[i] == DB && wbuf[i] == {DB{~m_lvl[i]}}) nl = ~m_lvl[i];
      if (m_lvl[i] && !nl) begin
        pls[i]        = 1'b1;
        press_edge[i] = cyc;
      end
`ifdef KEY_AUTOREPEAT_EN
      else if (!m_lvl[i] && !nl && ((cyc - press_edge[i]) % RP == 0)) begin
        pls[i] = 1'b1;
      end
`endif
      if (pls[i]) m_led[i] = ~m_led[i];
      m_lvl[i] = nl;
    end
    e.lvl = m_lvl;
    e.pls = pls;
    e.led = m_led;
    sb_q.push_back(e);
  endtask

  task automatic hold(input logic [N-1:0] kn, input int n);
    for (int k = 0; k < n; k++) step(kn);
  endtask

  // Assert reset between edges, check outputs clear immediately and stay
  // clear across edges, then release just after an edge.
  task automatic apply_reset(input logic [N-1:0] kn, input int edges);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    key_n = kn;
    #1;
    chk("rst_now_key_level", key_level, '1);
    chk("rst_now_press", press_pulse, '0);
    chk("rst_now_led", led_n, '1);
    repeat (edges) @(posedge clk);
    #1;
    chk("rst_hold_key_level", key_level, '1);
    chk("rst_hold_press", press_pulse, '0);
    chk("rst_hold_led", led_n, '1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare DUT outputs against the queued expectation after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("key_level", key_level, e.lvl);
        chk("press_pulse", press_pulse, e.pls);
        chk("led_n", led_n, e.led);
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    int           run [N];

    model_reset();
    // 1. Power-on reset with both keys held.
    apply_reset(2'b00, 3);
    hold(2'b00, 12);
    hold(2'b11, 12);

    // 2. Clean press and release of key0.
    hold(2'b10, 20);
    hold(2'b11, 12);

    // 3. Bounce on key0: short burst rejected, final low accepted.
    hold(2'b10, 3);
    hold(2'b11, 1);
    hold(2'b10, 10);
    hold(2'b11, 12);

    // 4. Simultaneous press (key0 LED currently lit from steps 2/3 parity).
    hold(2'b00, 12);
    hold(2'b11, 12);

    // 5. Reset mid-debounce, key still held afterwards.
    hold(2'b10, 3);
    apply_reset(2'b10, 2);
    hold(2'b10, 12);
    hold(2'b11, 12);

    // 6. Long hold (auto-repeat when enabled, single pulse otherwise).
    hold(2'b10, 36);
    hold(2'b11, 12);

    // 7. Random bouncy stimulus, independent run lengths per key.
    cur = '1;
    for (int i = 0; i < N; i++) run[i] = 1;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        run[i]--;
        if (run[i] <= 0) begin
          cur[i] = ~cur[i];
          if ($urandom_range(0, 2) == 0) run[i] = $urandom_range(1, DB - 1);
          else                           run[i] = $urandom_range(DB, 3 * DB + RP);
        end
      end
      step(cur);
    end
    hold(2'b11, 12);

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
